// File: rtl/arm_debug_display.sv
// Debug display stage: snapshots retiring PC/INSTR/WB and shows one page on HEX7..HEX0.
// Optional single-step run enable is built when ARM_DEBUG_SINGLE_STEP_EN is defined.

module arm_debug_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Idle (released) key level is 1, so reset forces every stage to 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;
endmodule

module arm_debug_display #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] wb_value_i,
  input  logic        valid_i,
  input  logic        freeze_i,
  input  logic        key_page_n,
  input  logic        key_step_n,
  input  logic        step_mode_i,
  output logic [6:0]  hex7,
  output logic [6:0]  hex6,
  output logic [6:0]  hex5,
  output logic [6:0]  hex4,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0,
  output logic [1:0]  page_o,
  output logic        run_en_o
);
  typedef enum logic [1:0] {
    PAGE_PC    = 2'd0,
    PAGE_INSTR = 2'd1,
    PAGE_WB    = 2'd2
  } page_e;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic            page_press_s;
  page_e           page_q, page_d;
  logic [31:0]     pc_q, instr_q, wb_q;
  logic [31:0]     sel_s;
  logic [7:0][6:0] hex_q, hex_d;

  arm_debug_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_page_db (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_page_n),
    .press_o (page_press_s)
  );

  always_comb begin
    page_d = page_q;
    case (page_q)
      PAGE_PC:    if (page_press_s) page_d = PAGE_INSTR; else page_d = PAGE_PC;
      PAGE_INSTR: if (page_press_s) page_d = PAGE_WB;    else page_d = PAGE_INSTR;
      PAGE_WB:    if (page_press_s) page_d = PAGE_PC;    else page_d = PAGE_WB;
      default:    page_d = PAGE_PC;
    endcase
  end

  always_comb begin
    sel_s = pc_q;
    case (page_q)
      PAGE_INSTR: sel_s = instr_q;
      PAGE_WB:    sel_s = wb_q;
      default:    sel_s = pc_q;
    endcase
    for (int i = 0; i < 8; i++) begin
      hex_d[i] = seg7(sel_s[4*i +: 4]);
    end
  end

  // Capture and page advance are independent, so a coincident press and retire both land.
  always_ff @(posedge clk) begin
    if (!rst) begin
      page_q  <= PAGE_PC;
      pc_q    <= 32'd0;
      instr_q <= 32'd0;
      wb_q    <= 32'd0;
      hex_q   <= {8{7'b1000000}};
    end else begin
      page_q <= page_d;
      if (valid_i && !freeze_i) begin
        pc_q    <= pc_i;
        instr_q <= instr_i;
        wb_q    <= wb_value_i;
      end
      hex_q <= hex_d;
    end
  end

  assign hex7   = hex_q[7];
  assign hex6   = hex_q[6];
  assign hex5   = hex_q[5];
  assign hex4   = hex_q[4];
  assign hex3   = hex_q[3];
  assign hex2   = hex_q[2];
  assign hex1   = hex_q[1];
  assign hex0   = hex_q[0];
  assign page_o = page_q;

`ifdef ARM_DEBUG_SINGLE_STEP_EN
  logic step_press_s;
  logic run_en_q, run_en_d;

  arm_debug_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_step_n),
    .press_o (step_press_s)
  );

  always_comb begin
    run_en_d = 1'b1;
    if (step_mode_i) begin
      run_en_d = step_press_s;
    end else begin
      run_en_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_en_q <= 1'b1;
    end else begin
      run_en_q <= run_en_d;
    end
  end

  assign run_en_o = run_en_q;
`else
  logic unused_step_s;
  assign unused_step_s = key_step_n ^ step_mode_i;
  assign run_en_o      = 1'b1;
`endif
endmodule

// File: tb/tb_arm_debug_display.sv
// Scoreboard bench for arm_debug_display with DEBOUNCE_CYCLES=4.
module tb_arm_debug_display;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, instr_i, wb_value_i;
  logic        valid_i, freeze_i, key_page_n, key_step_n, step_mode_i;
  logic [6:0]  hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0;
  logic [1:0]  page_o;
  logic        run_en_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [55:0] exp_q[$];
  logic [31:0] m_pc, m_instr, m_wb;
  logic [1:0]  m_page;
  logic [55:0] disp_s;

  always #5 clk = ~clk;
  assign disp_s = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

  arm_debug_display #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .instr_i(instr_i), .wb_value_i(wb_value_i),
    .valid_i(valid_i), .freeze_i(freeze_i), .key_page_n(key_page_n), .key_step_n(key_step_n),
    .step_mode_i(step_mode_i), .hex7(hex7), .hex6(hex6), .hex5(hex5), .hex4(hex4),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0), .page_o(page_o), .run_en_o(run_en_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [55:0] disp(input logic [31:0] v);
    logic [55:0] r;
    for (int i = 0; i < 8; i++) r[7*i +: 7] = seg(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] sel_model();
    case (m_page)
      2'd0: return m_pc;
      2'd1: return m_instr;
      default: return m_wb;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected();
    exp_q.push_back(disp(sel_model()));
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check_eq(tag, {8'd0, disp_s}, {8'd0, exp_q.pop_front()});
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    rst = 1'b1;
    m_pc = 32'd0; m_instr = 32'd0; m_wb = 32'd0; m_page = 2'd0;
  endtask

  task automatic capture(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] wb,
                         input logic frz);
    pc_i = pc; instr_i = ins; wb_value_i = wb; freeze_i = frz; valid_i = 1'b1;
    tick();
    valid_i = 1'b0; freeze_i = 1'b0;
    check_eq("hex_latency_hold", {8'd0, disp_s}, {8'd0, disp(sel_model())});
    if (!frz) begin
      m_pc = pc; m_instr = ins; m_wb = wb;
    end
    push_expected();
    tick();
    pop_check(frz ? "frozen_display" : "captured_display");
  endtask

  task automatic page_key(input int low_cycles, output int changes);
    logic [1:0] prev;
    changes = 0;
    prev = page_o;
    key_page_n = 1'b0;
    for (int i = 0; i < low_cycles + 10; i++) begin
      if (i == low_cycles) key_page_n = 1'b1;
      tick();
      if (page_o != prev) changes++;
      prev = page_o;
    end
  endtask

  task automatic page_press(input string tag);
    int ch;
    page_key(10, ch);
    m_page = (m_page == 2'd2) ? 2'd0 : m_page + 2'd1;
    check_eq({tag, "_page"}, {62'd0, page_o}, {62'd0, m_page});
    check_eq({tag, "_changes"}, 64'(ch), 64'd1);
    push_expected();
    pop_check({tag, "_display"});
  endtask

  initial begin
    int ch;
    int found;
    int hi_cnt;
    int rise_cnt;
    logic prev_run;
    valid_i = 1'b0; freeze_i = 1'b0; key_page_n = 1'b1; key_step_n = 1'b1; step_mode_i = 1'b0;
    pc_i = 32'd0; instr_i = 32'd0; wb_value_i = 32'd0;

    // 1. reset
    do_reset(3);
    tick();
    check_eq("reset_hex", {8'd0, disp_s}, {8'd0, {8{7'h40}}});
    check_eq("reset_page", {62'd0, page_o}, 64'd0);
    check_eq("reset_run_en", {63'd0, run_en_o}, 64'd1);

    // 2./3. capture, freeze, all-F
    capture(32'h0000_1A3C, 32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
    capture(32'hFFFF_FFFF, 32'h1111_2222, 32'h3333_4444, 1'b1);
    capture(32'hFFFF_FFFF, 32'h89AB_CDEF, 32'h5A5A_0F0F, 1'b0);

    // 4. bounce then real press
    page_key(3, ch);
    check_eq("bounce_page", {62'd0, page_o}, 64'd0);
    check_eq("bounce_changes", 64'(ch), 64'd0);
    page_press("press1");

    // 5. three more presses, then a press coincident with capture
    page_press("press2");
    page_press("press3");
    page_press("press4");
    pc_i = m_pc; instr_i = m_instr;
    key_page_n = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      logic [1:0] prev;
      prev = page_o;
      wb_value_i = 32'hC0DE_0000 + 32'(k);
      valid_i = 1'b1;
      tick();
      if (page_o != prev) begin
        found = 1;
        m_wb = wb_value_i;
      end
    end
    valid_i = 1'b0;
    key_page_n = 1'b1;
    check_eq("coincident_seen", 64'(found), 64'd1);
    m_page = (m_page == 2'd2) ? 2'd0 : m_page + 2'd1;
    check_eq("coincident_page", {62'd0, page_o}, {62'd0, m_page});
    tick();
    push_expected();
    pop_check("coincident_display");
    for (int i = 0; i < 10; i++) tick();
    check_eq("release_page", {62'd0, page_o}, {62'd0, m_page});

    // reset mid page press discards it
    key_page_n = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    do_reset(2);
    tick(); tick();
    key_page_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check_eq("rst_mid_press_page", {62'd0, page_o}, 64'd0);
    push_expected();
    pop_check("rst_mid_press_display");

    // 6. single step
    step_mode_i = 1'b1;
    tick(); tick();
`ifdef ARM_DEBUG_SINGLE_STEP_EN
    check_eq("step_mode_low", {63'd0, run_en_o}, 64'd0);
`else
    check_eq("step_ignored", {63'd0, run_en_o}, 64'd1);
`endif
    hi_cnt = 0; rise_cnt = 0; prev_run = run_en_o;
    for (int p = 0; p < 2; p++) begin
      key_step_n = 1'b0;
      for (int i = 0; i < 22; i++) begin
        if (i == 10) key_step_n = 1'b1;
        tick();
        if (run_en_o) hi_cnt++;
        if (run_en_o && !prev_run) rise_cnt++;
        prev_run = run_en_o;
      end
    end
`ifdef ARM_DEBUG_SINGLE_STEP_EN
    check_eq("step_high_cycles", 64'(hi_cnt), 64'd2);
    check_eq("step_pulses", 64'(rise_cnt), 64'd2);
    key_step_n = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    do_reset(2);
    tick();
    hi_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) key_step_n = 1'b1;
      tick();
      if (run_en_o) hi_cnt++;
    end
    check_eq("step_rst_mid_press", 64'(hi_cnt), 64'd0);
    step_mode_i = 1'b0;
    tick();
    check_eq("step_mode_off", {63'd0, run_en_o}, 64'd1);
`else
    check_eq("run_en_tied_high", 64'(hi_cnt), 64'd44);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
